// File: rtl/computational_unit_param.sv
// Parametrised datapath for the microcontroller core. It holds the operand, result,
// index and output registers, a data-bus mux, an ALU and a sequential shift-add multiplier.
// Define CU_SATURATE_EN to make add/sub signed and saturating, with r_carry reporting overflow.
module computational_unit_param #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     i_pins,
    input  logic [DATA_W-1:0]     dm,
    input  logic [3:0]            ir_nibble,
    input  logic [3:0]            source_sel,
    input  logic [8:0]            reg_en,
    input  logic                  i_sel,
    input  logic                  x_sel,
    input  logic                  y_sel,
    output logic [DATA_W-1:0]     data_bus,
    output logic [DATA_W-1:0]     x0,
    output logic [DATA_W-1:0]     x1,
    output logic [DATA_W-1:0]     y0,
    output logic [DATA_W-1:0]     y1,
    output logic [DATA_W-1:0]     r,
    output logic [DATA_W-1:0]     m,
    output logic [DATA_W-1:0]     i,
    output logic [DATA_W-1:0]     o_reg,
    output logic [2*DATA_W-1:0]   from_CU,
    output logic                  r_eq_0,
    output logic                  r_carry,
    output logic                  busy
);

    typedef enum logic {
        ST_IDLE,
        ST_MUL
    } state_t;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

    state_t                state_q, state_d;
    logic [DATA_W-1:0]     x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
    logic [DATA_W-1:0]     r_q, r_d, m_q, m_d, i_q, i_d, o_reg_q, o_reg_d;
    logic                  r_eq_0_q, r_eq_0_d, r_carry_q, r_carry_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [2*DATA_W-1:0]   mcand_q, mcand_d, acc_q, acc_d;
    logic [DATA_W-1:0]     mplier_q, mplier_d;
    logic                  hi_sel_q, hi_sel_d;

    logic [DATA_W-1:0]     bus;
    logic [DATA_W-1:0]     pm_data;
    logic [DATA_W-1:0]     i_mux;
    logic [DATA_W-1:0]     x_op, y_op;
    logic [2:0]            alu_f;
    logic                  alu_mod;
    logic                  is_mul;
    logic [DATA_W-1:0]     add_sum, sub_diff;
    logic                  add_cy, sub_bw;
    logic [DATA_W-1:0]     alu_res;
    logic                  alu_cy;
    logic                  alu_sets_cy;
    logic [2*DATA_W-1:0]   partial;
    logic [2*DATA_W-1:0]   acc_next;
    logic [DATA_W-1:0]     mul_half;
    logic                  unused_reg_en7;

    assign unused_reg_en7 = reg_en[7];
    assign pm_data        = DATA_W'(ir_nibble);

    // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        bus = '0;
        case (source_sel)
            4'd0:    bus = x0_q;
            4'd1:    bus = x1_q;
            4'd2:    bus = y0_q;
            4'd3:    bus = y1_q;
            4'd4:    bus = r_q;
            4'd5:    bus = m_q;
            4'd6:    bus = i_q;
            4'd7:    bus = dm;
            4'd8:    bus = pm_data;
            4'd9:    bus = i_pins;
            default: bus = '0;
        endcase
    end

    assign i_mux   = i_sel ? (i_q + m_q) : bus;
    assign x_op    = x_sel ? x1_q : x0_q;
    assign y_op    = y_sel ? y1_q : y0_q;
    assign alu_f   = ir_nibble[2:0];
    assign alu_mod = ir_nibble[3];
    assign is_mul  = (alu_f == 3'b011) || (alu_f == 3'b100);

    assign {add_cy, add_sum}  = {1'b0, x_op} + {1'b0, y_op};
    assign {sub_bw, sub_diff} = {1'b0, x_op} - {1'b0, y_op};

`ifdef CU_SATURATE_EN
    localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    logic       add_ovf, sub_ovf;
    logic [1:0] unused_carries;

    assign unused_carries = {add_cy, sub_bw};
    // Signed overflow: the result sign disagrees with x while the operand signs make that impossible.
    assign add_ovf = (x_op[DATA_W-1] == y_op[DATA_W-1]) && (add_sum[DATA_W-1] != x_op[DATA_W-1]);
    assign sub_ovf = (x_op[DATA_W-1] != y_op[DATA_W-1]) && (sub_diff[DATA_W-1] != x_op[DATA_W-1]);
`endif

    always_comb begin
        alu_res     = r_q;
        alu_cy      = r_carry_q;
        alu_sets_cy = 1'b0;
        case (alu_f)
            3'b000: alu_res = alu_mod ? r_q : -x_op;
            3'b001: begin
                alu_sets_cy = 1'b1;
`ifdef CU_SATURATE_EN
                alu_res = sub_ovf ? (x_op[DATA_W-1] ? SAT_MIN : SAT_MAX) : sub_diff;
                alu_cy  = sub_ovf;
`else
                alu_res = sub_diff;
                alu_cy  = sub_bw;
`endif
            end
            3'b010: begin
                alu_sets_cy = 1'b1;
`ifdef CU_SATURATE_EN
                alu_res = add_ovf ? (x_op[DATA_W-1] ? SAT_MIN : SAT_MAX) : add_sum;
                alu_cy  = add_ovf;
`else
                alu_res = add_sum;
                alu_cy  = add_cy;
`endif
            end
            3'b101:  alu_res = x_op ^ y_op;
            3'b110:  alu_res = x_op & y_op;
            3'b111:  alu_res = alu_mod ? r_q : ~x_op;
            default: alu_res = r_q;
        endcase
    end

    // One shift-add step: add the shifted multiplicand when the current multiplier bit is set.
    assign partial  = mplier_q[0] ? mcand_q : '0;
    assign acc_next = acc_q + partial;
    assign mul_half = hi_sel_q ? acc_next[2*DATA_W-1:DATA_W] : acc_next[DATA_W-1:0];

    always_comb begin
        x0_d    = reg_en[0] ? bus : x0_q;
        x1_d    = reg_en[1] ? bus : x1_q;
        y0_d    = reg_en[2] ? bus : y0_q;
        y1_d    = reg_en[3] ? bus : y1_q;
        m_d     = reg_en[5] ? bus : m_q;
        i_d     = reg_en[6] ? i_mux : i_q;
        o_reg_d = reg_en[8] ? bus : o_reg_q;

        state_d   = state_q;
        r_d       = r_q;
        r_eq_0_d  = r_eq_0_q;
        r_carry_d = r_carry_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        hi_sel_d  = hi_sel_q;

        case (state_q)
            ST_IDLE: begin
                if (reg_en[4]) begin
                    if (is_mul) begin
                        state_d  = ST_MUL;
                        mcand_d  = {{DATA_W{1'b0}}, x_op};
                        mplier_d = y_op;
                        acc_d    = '0;
                        cnt_d    = '0;
                        hi_sel_d = (alu_f == 3'b011);
                    end else begin
                        r_d      = alu_res;
                        r_eq_0_d = (alu_res == '0);
                        if (alu_sets_cy) begin
                            r_carry_d = alu_cy;
                        end
                    end
                end
            end
            ST_MUL: begin
                acc_d    = acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    state_d  = ST_IDLE;
                    r_d      = mul_half;
                    r_eq_0_d = (mul_half == '0);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            x0_q      <= '0;
            x1_q      <= '0;
            y0_q      <= '0;
            y1_q      <= '0;
            r_q       <= '0;
            m_q       <= '0;
            i_q       <= '0;
            o_reg_q   <= '0;
            r_eq_0_q  <= 1'b1;
            r_carry_q <= 1'b0;
            cnt_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            hi_sel_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            x0_q      <= x0_d;
            x1_q      <= x1_d;
            y0_q      <= y0_d;
            y1_q      <= y1_d;
            r_q       <= r_d;
            m_q       <= m_d;
            i_q       <= i_d;
            o_reg_q   <= o_reg_d;
            r_eq_0_q  <= r_eq_0_d;
            r_carry_q <= r_carry_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            hi_sel_q  <= hi_sel_d;
        end
    end

    assign data_bus = bus;
    assign x0       = x0_q;
    assign x1       = x1_q;
    assign y0       = y0_q;
    assign y1       = y1_q;
    assign r        = r_q;
    assign m        = m_q;
    assign i        = i_q;
    assign o_reg    = o_reg_q;
    assign from_CU  = {o_reg_q, o_reg_q};
    assign r_eq_0   = r_eq_0_q;
    assign r_carry  = r_carry_q;
    assign busy     = (state_q == ST_MUL);

endmodule

// File: tb/tb_computational_unit_param.sv
// Directed bench for computational_unit_param (DATA_W=8): expected values are queued
// as stimulus is applied and popped when the matching output is sampled.
module tb_computational_unit_param;

    localparam int W = 8;
    localparam int C = 4;

`ifdef CU_SATURATE_EN
    localparam logic [W-1:0] ADD_7F_R   = 8'h7F;
    localparam logic         ADD_7F_C   = 1'b1;
    localparam logic         ADD_FF_C   = 1'b0;
    localparam logic         SUB_C      = 1'b0;
`else
    localparam logic [W-1:0] ADD_7F_R   = 8'h80;
    localparam logic         ADD_7F_C   = 1'b0;
    localparam logic         ADD_FF_C   = 1'b1;
    localparam logic         SUB_C      = 1'b1;
`endif

    logic           clk;
    logic           reset;
    logic [W-1:0]   i_pins, dm;
    logic [3:0]     ir_nibble, source_sel;
    logic [8:0]     reg_en;
    logic           i_sel, x_sel, y_sel;
    logic [W-1:0]   data_bus, x0, x1, y0, y1, r, m, i, o_reg;
    logic [2*W-1:0] from_CU;
    logic           r_eq_0, r_carry, busy;

    computational_unit_param #(.DATA_W(W), .CNT_W(C)) dut (
        .clk(clk), .reset(reset), .i_pins(i_pins), .dm(dm), .ir_nibble(ir_nibble),
        .source_sel(source_sel), .reg_en(reg_en), .i_sel(i_sel), .x_sel(x_sel), .y_sel(y_sel),
        .data_bus(data_bus), .x0(x0), .x1(x1), .y0(y0), .y1(y1), .r(r), .m(m), .i(i),
        .o_reg(o_reg), .from_CU(from_CU), .r_eq_0(r_eq_0), .r_carry(r_carry), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [15:0] val;
    } exp_t;

    exp_t sb[$];
    int   vectors    = 0;
    int   miscompares = 0;

    task automatic expect_val(input string tag, input logic [15:0] val);
        sb.push_back('{tag: tag, val: val});
    endtask

    task automatic check(input logic [15:0] obs);
        exp_t e;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_empty observed=%h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                miscompares++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int idx, input logic [W-1:0] val);
        source_sel = 4'd9;
        i_pins     = val;
        reg_en     = 9'b1 << idx;
        tick();
        reg_en     = '0;
    endtask

    task automatic alu_op(input logic [3:0] nib);
        ir_nibble = nib;
        reg_en    = 9'h010;
        tick();
        reg_en    = '0;
    endtask

    initial begin
        reset = 1'b1; i_pins = '0; dm = '0; ir_nibble = '0; source_sel = '0;
        reg_en = '0; i_sel = 1'b0; x_sel = 1'b0; y_sel = 1'b0;
        tick();
        tick();
        expect_val("reset_r", 16'h0000);      check(16'(r));
        expect_val("reset_r_eq_0", 16'h1);    check(16'(r_eq_0));
        expect_val("reset_busy", 16'h0);      check(16'(busy));
        reset = 1'b0;
        tick();

        // Low half of 0x0F*0x11, with busy tracked edge by edge.
        load(0, 8'h0F);
        load(2, 8'h11);
        alu_op(4'h4);
        expect_val("mul_busy_e0", 16'h1);     check(16'(busy));
        for (int k = 1; k < W; k++) begin
            tick();
            expect_val($sformatf("mul_busy_e%0d", k), 16'h1); check(16'(busy));
        end
        tick();
        expect_val("mul_lo_busy_done", 16'h0); check(16'(busy));
        expect_val("mul_lo_r", 16'h00FF);      check(16'(r));
        expect_val("mul_lo_r_eq_0", 16'h0);    check(16'(r_eq_0));

        alu_op(4'h3);
        for (int k = 1; k <= W; k++) tick();
        expect_val("mul_hi_busy_done", 16'h0); check(16'(busy));
        expect_val("mul_hi_r", 16'h0000);      check(16'(r));
        expect_val("mul_hi_r_eq_0", 16'h1);    check(16'(r_eq_0));

        // Operand write at E3 and an add request at E5 must not disturb the product.
        load(0, 8'h0C);
        load(2, 8'h0B);
        alu_op(4'h4);
        tick();
        tick();
        load(0, 8'h55);
        tick();
        alu_op(4'h2);
        expect_val("mid_add_ignored_r", 16'h0000); check(16'(r));
        expect_val("mid_busy_e5", 16'h1);          check(16'(busy));
        tick();
        tick();
        tick();
        expect_val("mid_mul_r", 16'h0084);   check(16'(r));
        expect_val("mid_busy_e8", 16'h0);    check(16'(busy));
        expect_val("mid_x0_written", 16'h0055); check(16'(x0));

        // Add / subtract boundaries.
        load(0, 8'h7F);
        load(2, 8'h01);
        alu_op(4'h2);
        expect_val("add_7f_r", 16'(ADD_7F_R)); check(16'(r));
        expect_val("add_7f_c", 16'(ADD_7F_C)); check(16'(r_carry));
        expect_val("add_7f_eq", 16'h0);        check(16'(r_eq_0));
        load(0, 8'hFF);
        alu_op(4'h2);
        expect_val("add_ff_r", 16'h0000);      check(16'(r));
        expect_val("add_ff_c", 16'(ADD_FF_C)); check(16'(r_carry));
        expect_val("add_ff_eq", 16'h1);        check(16'(r_eq_0));
        load(0, 8'h10);
        load(2, 8'h20);
        alu_op(4'h1);
        expect_val("sub_r", 16'h00F0);         check(16'(r));
        expect_val("sub_c", 16'(SUB_C));       check(16'(r_carry));

        // Logic ops on the x1/y1 operands.
        load(1, 8'h3C);
        load(3, 8'h0F);
        x_sel = 1'b1;
        y_sel = 1'b1;
        alu_op(4'h5);
        expect_val("xor_r", 16'h0033);         check(16'(r));
        expect_val("xor_c_held", 16'(SUB_C));  check(16'(r_carry));
        alu_op(4'h6);
        expect_val("and_r", 16'h000C);         check(16'(r));
        alu_op(4'h7);
        expect_val("not_r", 16'h00C3);         check(16'(r));
        alu_op(4'h0);
        expect_val("neg_r", 16'h00C4);         check(16'(r));
        alu_op(4'h8);
        expect_val("pass_r", 16'h00C4);        check(16'(r));
        x_sel = 1'b0;
        y_sel = 1'b0;

        // Index wrap, bus sources, output register.
        load(6, 8'hF0);
        load(5, 8'h20);
        i_sel  = 1'b1;
        reg_en = 9'h040;
        tick();
        reg_en = '0;
        i_sel  = 1'b0;
        expect_val("i_wrap", 16'h0010);        check(16'(i));
        source_sel = 4'd12;
        #1;
        expect_val("bus_sel12", 16'h0000);     check(16'(data_bus));
        source_sel = 4'd8;
        ir_nibble  = 4'hA;
        #1;
        expect_val("bus_pm_data", 16'h000A);   check(16'(data_bus));
        source_sel = 4'd6;
        #1;
        expect_val("bus_i", 16'h0010);         check(16'(data_bus));
        load(8, 8'hA5);
        expect_val("from_cu", 16'hA5A5);       check(from_CU);

        // Asynchronous reset between edges takes effect before the next edge.
        #2;
        reset = 1'b1;
        #1;
        expect_val("async_r", 16'h0000);       check(16'(r));
        expect_val("async_r_eq_0", 16'h1);     check(16'(r_eq_0));
        expect_val("async_i", 16'h0000);       check(16'(i));
        expect_val("async_o_reg", 16'h0000);   check(16'(o_reg));
        tick();
        reset = 1'b0;
        tick();

        // Reset at E4 of a multiply aborts it; a fresh multiply then completes.
        load(0, 8'hC8);
        load(2, 8'h64);
        alu_op(4'h3);
        tick();
        tick();
        tick();
        #3;
        reset = 1'b1;
        #1;
        expect_val("abort_busy", 16'h0);       check(16'(busy));
        expect_val("abort_r", 16'h0000);       check(16'(r));
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        load(0, 8'hC8);
        load(2, 8'h64);
        alu_op(4'h3);
        tick();
        expect_val("fresh_busy", 16'h1);       check(16'(busy));
        for (int k = 2; k <= W; k++) tick();
        expect_val("fresh_r", 16'h004E);       check(16'(r));
        expect_val("fresh_busy_done", 16'h0);  check(16'(busy));

        vectors++;
        assert (sb.size() == 0) else begin
            miscompares++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
